// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit serializer and the receiver.
// Optional transmit FIFO is selected with the UART_TX_FIFO_EN macro (see uart_tx_serializer).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Parity mode encodings; 3 is treated as "none" as well.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Stop-bit encodings.
  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } tx_state_e;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic [1:0] mode);
    return (^b) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with full/empty flags, placed in front of the transmit FSM when
// UART_TX_FIFO_EN is defined. Depth must be a power of two so pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (PtrW + 1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write while full is legal only when a pop frees the slot in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: parallel byte in over valid/ready, serial data/valid_data out.
// Frame: start, 8 data bits LSB first, optional parity, one or two stop bits.
// Define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry input FIFO ahead of the FSM.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           paritybit,
  input  logic                 stopbit,
  output logic                 data,
  output logic                 valid_data,
  output logic                 busy
);

  localparam int unsigned    CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LastIdx = 3'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] byte_q;
  logic [1:0]           par_q;
  logic                 stop_q;
  logic                 run_q;
  logic                 data_q, valid_q, busy_q;

  logic                 bit_done, last_stop, fsm_ready, take, line_bit;
  logic                 src_valid, src_stop;
  logic [DATA_BITS-1:0] src_data;
  logic [1:0]           src_par;

  assign bit_done  = (cnt_q == CntMax);
  assign last_stop = (state_q == StStop2) || ((state_q == StStop1) && (stop_q == STOP_1));
  // run_q keeps the handshake closed while in reset and for the reset-release cycle.
  assign fsm_ready = run_q && ((state_q == StIdle) || (last_stop && bit_done));
  assign take      = fsm_ready && src_valid;

`ifdef UART_TX_FIFO_EN
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS+2:0]   fifo_rdata;

  assign in_ready  = run_q && !fifo_full;
  assign src_valid = !fifo_empty;
  assign {src_par, src_stop, src_data} = fifo_rdata;

  // Frame config travels with its byte so it applies to the frame it was written with.
  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS + 3)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (in_valid && in_ready),
    .wr_data_i ({paritybit, stopbit, in_data}),
    .rd_en_i   (take),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );
`else
  logic unused_fifo_depth;
  assign unused_fifo_depth = ^FIFO_DEPTH;

  assign in_ready  = fsm_ready;
  assign src_valid = in_valid;
  assign src_data  = in_data;
  assign src_par   = paritybit;
  assign src_stop  = stopbit;
`endif

  // Serial level for the bit period the FSM is currently in.
  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      StStart:  line_bit = 1'b0;
      StData:   line_bit = byte_q[idx_q];
      StParity: line_bit = parity_bit(byte_q, par_q);
      default:  line_bit = 1'b1;
    endcase
  end

  // Transmit FSM with registered line outputs that trail the state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      par_q   <= PAR_NONE;
      stop_q  <= STOP_1;
      run_q   <= 1'b0;
      data_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      data_q  <= line_bit;
      valid_q <= (cnt_q == '0);
      busy_q  <= (state_q != StIdle);

      if (take || bit_done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (take) begin
        byte_q <= src_data;
        par_q  <= src_par;
        stop_q <= src_stop;
      end

      case (state_q)
        StIdle: begin
          if (take) state_q <= StStart;
        end
        StStart: begin
          if (bit_done) begin
            state_q <= StData;
            idx_q   <= '0;
          end
        end
        StData: begin
          if (bit_done) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == LastIdx) begin
              state_q <= parity_enabled(par_q) ? StParity : StStop1;
            end
          end
        end
        StParity: begin
          if (bit_done) state_q <= StStop1;
        end
        StStop1: begin
          if (bit_done) begin
            if (stop_q == STOP_2) begin
              state_q <= StStop2;
            end else begin
              state_q <= take ? StStart : StIdle;
            end
          end
        end
        StStop2: begin
          if (bit_done) state_q <= take ? StStart : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data       = data_q;
  assign valid_data = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer (CLKS_PER_BIT = 1).
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] paritybit = 2'd0;
  logic       stopbit = 1'b0;
  logic       data, valid_data, busy;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .paritybit  (paritybit),
    .stopbit    (stopbit),
    .data       (data),
    .valid_data (valid_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sends one byte and checks every bit period; frame is listed first-bit-first from bit nbits-1.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic [1:0] p,
                            input logic s, input logic [11:0] frame, input int nbits);
    in_data   = b;
    paritybit = p;
    stopbit   = s;
    in_valid  = 1'b1;
    chk({tag, "_ready_idle"}, in_ready, 1);
    tick();
    // Scramble inputs mid-frame; the latched config must keep the frame intact.
    in_valid  = 1'b0;
    in_data   = ~b;
    paritybit = (p == 2'd0) ? 2'd1 : 2'd0;
    stopbit   = ~s;
    chk({tag, "_data_lag"}, data, 1);
    chk({tag, "_busy_lag"}, busy, 0);
    for (int i = 0; i < nbits; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), data, frame[nbits-1-i]);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_vd%0d", tag, i), valid_data, 1);
      chk($sformatf("%s_rdy%0d", tag, i), in_ready, (i >= nbits - 2));
    end
    tick();
    chk({tag, "_idle_data"}, data, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
    paritybit = 2'd0;
    stopbit   = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_data", data, 1);
    chk("rst_valid", valid_data, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("rel_ready", in_ready, 1);
    chk("rel_valid", valid_data, 1);
    chk("rel_data", data, 1);
    chk("rel_busy", busy, 0);

`ifndef UART_TX_FIFO_EN
    // Single frames: start, data LSB first, parity, stop(s).
    send_frame("x53_none", 8'h53, 2'd0, 1'b0, 12'b00_0110010101, 10);
    send_frame("x53_even", 8'h53, 2'd1, 1'b0, 12'b0_01100101001, 11);
    send_frame("x53_odd",  8'h53, 2'd2, 1'b0, 12'b0_01100101011, 11);
    send_frame("x53_p3",   8'h53, 2'd3, 1'b0, 12'b00_0110010101, 10);
    send_frame("xff_even2", 8'hFF, 2'd1, 1'b1, 12'b011111111011, 12);
    send_frame("x00_even2", 8'h00, 2'd1, 1'b1, 12'b000000000011, 12);
    send_frame("xff_odd2",  8'hFF, 2'd2, 1'b1, 12'b011111111111, 12);
    send_frame("x00_odd2",  8'h00, 2'd2, 1'b1, 12'b000000000111, 12);

    // Back-to-back frames with in_valid held high.
    begin
      logic [7:0]  bytes [4];
      logic [39:0] stream;
      int          k, hs, rdy_cnt;
      logic        r;
      bytes[0] = 8'hAA;
      bytes[1] = 8'h55;
      bytes[2] = 8'h00;
      bytes[3] = 8'hFF;
      stream = {10'b0010101011, 10'b0101010101, 10'b0000000001, 10'b0111111111};
      k = 0;
      hs = 0;
      rdy_cnt = 0;
      in_data  = bytes[0];
      in_valid = 1'b1;
      for (int c = 0; c <= 41; c++) begin
        r = in_ready;
        if (c >= 1 && c <= 40 && r) rdy_cnt++;
        tick();
        if (r && in_valid) begin
          hs++;
          k++;
          if (k < 4) in_data = bytes[k];
          else in_valid = 1'b0;
        end
        if (c >= 1 && c <= 40) begin
          chk($sformatf("b2b_bit%0d", c - 1), data, stream[39-(c-1)]);
          chk($sformatf("b2b_busy%0d", c - 1), busy, 1);
          chk($sformatf("b2b_vd%0d", c - 1), valid_data, 1);
        end
      end
      chk("b2b_end_data", data, 1);
      chk("b2b_end_busy", busy, 0);
      chk("b2b_handshakes", hs, 4);
      chk("b2b_ready_pulses", rdy_cnt, 4);
    end

    // Reset on the 5th data bit of 0x0F (that bit is 0), then a clean frame.
    in_data  = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_pre_data", data, 0);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_data", data, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid_data, 0);
    chk("abort_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("abort_rel_ready", in_ready, 1);
    chk("abort_rel_valid", valid_data, 1);
    send_frame("post_abort", 8'h53, 2'd0, 1'b0, 12'b00_0110010101, 10);
`else
    // FIFO burst: six bytes offered back to back, decoded from the serial line.
    begin
      logic [7:0] bytes6 [6];
      logic [7:0] rx [$];
      logic [7:0] sh;
      int         k, st, bn;
      logic       r, saw_full;
      bytes6[0] = 8'h11;
      bytes6[1] = 8'h22;
      bytes6[2] = 8'h33;
      bytes6[3] = 8'h44;
      bytes6[4] = 8'h55;
      bytes6[5] = 8'h66;
      k = 0;
      st = 0;
      bn = 0;
      sh = 8'h00;
      saw_full = 1'b0;
      paritybit = 2'd0;
      stopbit   = 1'b0;
      in_data   = bytes6[0];
      in_valid  = 1'b1;
      for (int c = 0; c < 120; c++) begin
        r = in_ready;
        if (!r && in_valid) saw_full = 1'b1;
        tick();
        if (r && in_valid) begin
          k++;
          if (k < 6) in_data = bytes6[k];
          else in_valid = 1'b0;
        end
        if (st == 0) begin
          if (data == 1'b0) begin
            st = 1;
            bn = 0;
          end
        end else if (st == 1) begin
          sh[bn] = data;
          bn++;
          if (bn == 8) begin
            rx.push_back(sh);
            st = 2;
          end
        end else begin
          st = 0;
        end
      end
      chk("fifo_saw_full", saw_full, 1);
      chk("fifo_writes", k, 6);
      chk("fifo_rx_count", rx.size(), 6);
      for (int i = 0; i < 6; i++) begin
        if (i < rx.size()) chk($sformatf("fifo_byte%0d", i), rx[i], bytes6[i]);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
